// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Purpose:
//   Issue stage sitting directly in front of the 64-bit ALU of the sequential
//   RV64I core. It decodes an OP / OP-IMM instruction into an ALU operation
//   select, picks operand B (rs2 or the immediate), derives the shift amount
//   and carry-in, and flags anything that is not a legal OP / OP-IMM encoding.
//   Results are held in a two-entry skid buffer (main entry M, skid entry S).
//   in_ready depends only on registered state, so a stalling ALU never creates
//   a combinational ready path back upstream.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              synchronous kill of both buffer entries and the input
//   in_valid/in_ready  upstream handshake
//   in_opcode/funct3/funct7, in_rs1_val, in_rs2_val, in_imm, in_rd
//                      decoded instruction fields and operand values
//   out_valid/out_ready downstream (ALU) handshake
//   out_alu_op         0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//   out_a, out_b       ALU operands
//   out_shamt          out_b[$clog2(XLEN)-1:0]
//   out_cin            1 for SUB
//   out_rd             destination register
//   out_illegal        instruction was not a legal OP / OP-IMM
// -----------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int XLEN = 64,
   parameter int OPW  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_opcode,
   input  logic [2:0]               in_funct3,
   input  logic [6:0]               in_funct7,
   input  logic [XLEN-1:0]          in_rs1_val,
   input  logic [XLEN-1:0]          in_rs2_val,
   input  logic [XLEN-1:0]          in_imm,
   input  logic [4:0]               in_rd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPW-1:0]           out_alu_op,
   output logic [XLEN-1:0]          out_a,
   output logic [XLEN-1:0]          out_b,
   output logic [$clog2(XLEN)-1:0]  out_shamt,
   output logic                     out_cin,
   output logic [4:0]               out_rd,
   output logic                     out_illegal
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef enum logic [OPW-1:0] {
      ALU_ADD  = 'd0,
      ALU_SUB  = 'd1,
      ALU_AND  = 'd2,
      ALU_OR   = 'd3,
      ALU_XOR  = 'd4,
      ALU_SLL  = 'd5,
      ALU_SRL  = 'd6,
      ALU_SRA  = 'd7,
      ALU_SLT  = 'd8,
      ALU_SLTU = 'd9
   } alu_op_e;

   typedef struct packed {
      logic [OPW-1:0]  alu_op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic            cin;
      logic [4:0]      rd;
      logic            illegal;
   } entry_t;

   logic    is_op;
   logic    is_op_imm;
   logic    dec_legal;
   alu_op_e dec_op;
   entry_t  dec_entry;

   entry_t  m_q, m_d;
   entry_t  s_q, s_d;
   logic    m_valid_q, m_valid_d;
   logic    s_valid_q, s_valid_d;

   logic    accept;
   logic    drain;

   assign is_op     = (in_opcode == OPC_OP);
   assign is_op_imm = (in_opcode == OPC_OP_IMM);

   // Operation select from funct3. funct7[5] picks SUB (OP only) and SRA;
   // any non-canonical funct7 that happens to set bit 5 is caught by the
   // legality check below and forced back to ADD.
   always_comb begin
      dec_op = ALU_ADD;
      case (in_funct3)
         3'b000:  dec_op = (is_op && in_funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  dec_op = ALU_SLL;
         3'b010:  dec_op = ALU_SLT;
         3'b011:  dec_op = ALU_SLTU;
         3'b100:  dec_op = ALU_XOR;
         3'b101:  dec_op = in_funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  dec_op = ALU_OR;
         default: dec_op = ALU_AND;
      endcase
   end

   // Legality. For OP-IMM shifts only funct7[6:1] is checked because funct7[0]
   // is shamt[5] on RV64; non-shift OP-IMM instructions carry a plain immediate.
   always_comb begin
      dec_legal = 1'b0;
      if (is_op) begin
         dec_legal = (in_funct7 == 7'b0000000) ||
                     ((in_funct7 == 7'b0100000) &&
                      ((in_funct3 == 3'b000) || (in_funct3 == 3'b101)));
      end else if (is_op_imm) begin
         case (in_funct3)
            3'b001:  dec_legal = (in_funct7[6:1] == 6'b000000);
            3'b101:  dec_legal = (in_funct7[6:1] == 6'b000000) ||
                                 (in_funct7[6:1] == 6'b010000);
            default: dec_legal = 1'b1;
         endcase
      end
   end

   // Assemble the entry that would be written into the buffer. Illegal
   // instructions still travel downstream as a harmless ADD of zeros so the
   // later stage can raise the exception with the right rd.
   always_comb begin
      dec_entry         = '0;
      dec_entry.rd      = in_rd;
      dec_entry.illegal = !dec_legal;
      if (dec_legal) begin
         dec_entry.alu_op = dec_op;
         dec_entry.a      = in_rs1_val;
         dec_entry.b      = is_op ? in_rs2_val : in_imm;
         dec_entry.cin    = (dec_op == ALU_SUB);
      end
   end

   assign in_ready = !s_valid_q;
   assign accept   = in_valid && in_ready && !flush;
   assign drain    = m_valid_q && out_ready;

   // Skid buffer next state. S can only be occupied while M is full and
   // stalled, and in_ready is low whenever S is full, so a drain with S full
   // never coincides with an accept. flush overrides everything.
   always_comb begin
      m_d       = m_q;
      s_d       = s_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      if (flush) begin
         m_d       = '0;
         s_d       = '0;
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (drain) begin
         if (s_valid_q) begin
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
         end else if (accept) begin
            m_d       = dec_entry;
            m_valid_d = 1'b1;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!m_valid_q) begin
            m_d       = dec_entry;
            m_valid_d = 1'b1;
         end else begin
            s_d       = dec_entry;
            s_valid_d = 1'b1;
         end
      end
   end

   // Buffer registers; reset clears both entries and their data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q       <= '0;
         s_q       <= '0;
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
      end else begin
         m_q       <= m_d;
         s_q       <= s_d;
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
      end
   end

   assign out_valid   = m_valid_q;
   assign out_alu_op  = m_q.alu_op;
   assign out_a       = m_q.a;
   assign out_b       = m_q.b;
   assign out_shamt   = m_q.b[SHW-1:0];
   assign out_cin     = m_q.cin;
   assign out_rd      = m_q.rd;
   assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Testbench for alu_operand_stage. A queue-based model holds the instructions
// that have been accepted but not yet consumed by the ALU; the head of the
// queue is what the DUT must present, its length gives out_valid and in_ready.
// Directed sequences pin specific literal values, then randomized traffic with
// random back-pressure and occasional flushes runs against the model.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef struct packed {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [63:0] in_rs1_val = '0;
   logic [63:0] in_rs2_val = '0;
   logic [63:0] in_imm = '0;
   logic [4:0]  in_rd = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_alu_op;
   logic [63:0] out_a;
   logic [63:0] out_b;
   logic [5:0]  out_shamt;
   logic        out_cin;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int   nChecks = 0;
   int   nFails  = 0;
   exp_t expQ[$];

   alu_operand_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_funct3   (in_funct3),
      .in_funct7   (in_funct7),
      .in_rs1_val  (in_rs1_val),
      .in_rs2_val  (in_rs2_val),
      .in_imm      (in_imm),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_alu_op  (out_alu_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_shamt   (out_shamt),
      .out_cin     (out_cin),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   // Reference decode written as a mnemonic table plus the exceptional cases
   // (SUB, SRA, illegal encodings) applied on top.
   function automatic exp_t modelDecode(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [63:0] rs1,
                                        input logic [63:0] rs2, input logic [63:0] imm,
                                        input logic [4:0] rd);
      logic [3:0] table3 [8];
      exp_t       e;
      logic       legal;
      logic       isOp;
      logic       isImm;
      table3[0] = 4'd0; table3[1] = 4'd5; table3[2] = 4'd8; table3[3] = 4'd9;
      table3[4] = 4'd4; table3[5] = 4'd6; table3[6] = 4'd3; table3[7] = 4'd2;
      isOp  = (opc == OPC_OP);
      isImm = (opc == OPC_OP_IMM);
      if (isOp)
         legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      else if (isImm && f3 == 3'd1)
         legal = (f7 >> 1) == 7'd0;
      else if (isImm && f3 == 3'd5)
         legal = ((f7 >> 1) == 7'd0) || ((f7 >> 1) == 7'd16);
      else
         legal = isImm;
      e = '0;
      e.rd  = rd;
      e.ill = !legal;
      if (legal) begin
         e.op = table3[f3];
         if (isOp && f3 == 3'd0 && f7 == 7'h20) e.op = 4'd1;
         if (f3 == 3'd5 && f7[5]) e.op = 4'd7;
         e.a   = rs1;
         e.b   = isOp ? rs2 : imm;
         e.cin = (e.op == 4'd1);
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs, report whether the model says the input was
   // taken, and return 1 time unit after the clock edge.
   task automatic applyStimulus(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] rs1,
                                input logic [63:0] rs2, input logic [63:0] imm,
                                input logic [4:0] rd, input logic ordy, input logic fl,
                                output logic accepted);
      in_valid   = v;
      in_opcode  = opc;
      in_funct3  = f3;
      in_funct7  = f7;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
      in_imm     = imm;
      in_rd      = rd;
      out_ready  = ordy;
      flush      = fl;
      accepted   = v && (expQ.size() < 2) && !fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle(input logic ordy);
      logic dummy;
      applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 64'd0, 64'd0, 64'd0, 5'd0, ordy, 1'b0, dummy);
   endtask

   // Model update: on every edge retire the head if the ALU took it, then
   // append the newly accepted instruction; flush or reset empties the queue.
   always @(posedge clk) begin : modelStep
      logic acc;
      if (rst || flush) begin
         expQ.delete();
      end else begin
         acc = in_valid && (expQ.size() < 2);
         if (expQ.size() > 0 && out_ready) void'(expQ.pop_front());
         if (acc) expQ.push_back(modelDecode(in_opcode, in_funct3, in_funct7, in_rs1_val,
                                             in_rs2_val, in_imm, in_rd));
      end
   end

   // Compare process: on every falling edge outside reset the DUT must match
   // the model's view of the buffer.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("out_valid", 64'(out_valid), 64'(expQ.size() > 0));
         checkOutput("in_ready", 64'(in_ready), 64'(expQ.size() < 2));
         if (out_valid && expQ.size() > 0) begin
            checkOutput("out_alu_op", 64'(out_alu_op), 64'(expQ[0].op));
            checkOutput("out_a", out_a, expQ[0].a);
            checkOutput("out_b", out_b, expQ[0].b);
            checkOutput("out_shamt", 64'(out_shamt), 64'(expQ[0].b[5:0]));
            checkOutput("out_cin", 64'(out_cin), 64'(expQ[0].cin));
            checkOutput("out_rd", 64'(out_rd), 64'(expQ[0].rd));
            checkOutput("out_illegal", 64'(out_illegal), 64'(expQ[0].ill));
         end
      end
   end

   initial begin : mainSeq
      logic        acc;
      logic        pending;
      logic        rv;
      logic [6:0]  ropc;
      logic [2:0]  rf3;
      logic [6:0]  rf7;
      logic [63:0] rrs1;
      logic [63:0] rrs2;
      logic [63:0] rimm;
      logic [4:0]  rrd;
      logic        rordy;
      logic        rfl;
      int          sel;

      // Reset state
      #1 rst = 1'b1;
      #1;
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset out_a", out_a, 64'd0);
      checkOutput("reset out_b", out_b, 64'd0);
      checkOutput("reset out_rd", 64'(out_rd), 64'd0);
      checkOutput("reset out_alu_op", 64'(out_alu_op), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idleCycle(1'b1);

      // SUB with carry-in
      applyStimulus(1'b1, OPC_OP, 3'b000, 7'b0100000, 64'd5, 64'd7, 64'd0, 5'd3, 1'b1, 1'b0, acc);
      checkOutput("sub alu_op", 64'(out_alu_op), 64'd1);
      checkOutput("sub a", out_a, 64'd5);
      checkOutput("sub b", out_b, 64'd7);
      checkOutput("sub cin", 64'(out_cin), 64'd1);

      // OP-IMM shifts: SRAI and SRLI with shamt[5] set
      applyStimulus(1'b1, OPC_OP_IMM, 3'b101, 7'b0100000, 64'd9, 64'd0, 64'h403, 5'd4, 1'b1, 1'b0, acc);
      checkOutput("srai alu_op", 64'(out_alu_op), 64'd7);
      checkOutput("srai b", out_b, 64'h403);
      checkOutput("srai shamt", 64'(out_shamt), 64'd3);
      applyStimulus(1'b1, OPC_OP_IMM, 3'b101, 7'b0000001, 64'd9, 64'd0, 64'h023, 5'd5, 1'b1, 1'b0, acc);
      checkOutput("srli alu_op", 64'(out_alu_op), 64'd6);
      checkOutput("srli shamt", 64'(out_shamt), 64'h23);

      // Illegal opcode and illegal OP funct7
      applyStimulus(1'b1, 7'b0000011, 3'b000, 7'd0, 64'd77, 64'd88, 64'd99, 5'd6, 1'b1, 1'b0, acc);
      checkOutput("bad opc illegal", 64'(out_illegal), 64'd1);
      checkOutput("bad opc alu_op", 64'(out_alu_op), 64'd0);
      checkOutput("bad opc a", out_a, 64'd0);
      checkOutput("bad opc b", out_b, 64'd0);
      checkOutput("bad opc rd", 64'(out_rd), 64'd6);
      applyStimulus(1'b1, OPC_OP, 3'b001, 7'b0100000, 64'd1, 64'd2, 64'd0, 5'd7, 1'b1, 1'b0, acc);
      checkOutput("bad sll illegal", 64'(out_illegal), 64'd1);
      idleCycle(1'b1);

      // Back-pressure: two accepted, third held off, then all drain in order
      applyStimulus(1'b1, OPC_OP, 3'b000, 7'd0, 64'd1, 64'd1, 64'd0, 5'd10, 1'b0, 1'b0, acc);
      checkOutput("bp A rd", 64'(out_rd), 64'd10);
      checkOutput("bp A in_ready", 64'(in_ready), 64'd1);
      applyStimulus(1'b1, OPC_OP, 3'b100, 7'd0, 64'd2, 64'd2, 64'd0, 5'd11, 1'b0, 1'b0, acc);
      checkOutput("bp B in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp B rd held", 64'(out_rd), 64'd10);
      applyStimulus(1'b1, OPC_OP, 3'b110, 7'd0, 64'd3, 64'd3, 64'd0, 5'd12, 1'b0, 1'b0, acc);
      checkOutput("bp C not taken", 64'(acc), 64'd0);
      checkOutput("bp C rd held", 64'(out_rd), 64'd10);
      applyStimulus(1'b1, OPC_OP, 3'b110, 7'd0, 64'd3, 64'd3, 64'd0, 5'd12, 1'b1, 1'b0, acc);
      checkOutput("bp drain1 rd", 64'(out_rd), 64'd11);
      checkOutput("bp drain1 in_ready", 64'(in_ready), 64'd1);
      applyStimulus(1'b1, OPC_OP, 3'b110, 7'd0, 64'd3, 64'd3, 64'd0, 5'd12, 1'b1, 1'b0, acc);
      checkOutput("bp drain2 rd", 64'(out_rd), 64'd12);
      idleCycle(1'b1);
      checkOutput("bp empty", 64'(out_valid), 64'd0);

      // Flush of a full buffer with a valid input presented
      applyStimulus(1'b1, OPC_OP, 3'b000, 7'd0, 64'd1, 64'd1, 64'd0, 5'd20, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, OPC_OP, 3'b000, 7'd0, 64'd2, 64'd2, 64'd0, 5'd21, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, OPC_OP, 3'b000, 7'd0, 64'd3, 64'd3, 64'd0, 5'd22, 1'b1, 1'b1, acc);
      checkOutput("flush out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush in_ready", 64'(in_ready), 64'd1);
      idleCycle(1'b1);
      checkOutput("flush nothing emerges", 64'(out_valid), 64'd0);

      // Asynchronous reset between edges
      applyStimulus(1'b1, OPC_OP, 3'b111, 7'd0, 64'd4, 64'd4, 64'd0, 5'd25, 1'b0, 1'b0, acc);
      checkOutput("pre-rst out_valid", 64'(out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", 64'(out_valid), 64'd0);
      expQ.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      applyStimulus(1'b1, OPC_OP, 3'b010, 7'd0, 64'd6, 64'd8, 64'd0, 5'd26, 1'b1, 1'b0, acc);
      checkOutput("post-rst out_valid", 64'(out_valid), 64'd1);
      checkOutput("post-rst rd", 64'(out_rd), 64'd26);
      checkOutput("post-rst alu_op", 64'(out_alu_op), 64'd8);

      // Randomized traffic; an un-accepted valid input is held until taken
      pending = 1'b0;
      rv = 1'b0; ropc = '0; rf3 = '0; rf7 = '0; rrs1 = '0; rrs2 = '0; rimm = '0; rrd = '0;
      for (int c = 0; c < 800; c++) begin
         if (!pending) begin
            sel  = $urandom_range(0, 19);
            ropc = (sel < 9) ? OPC_OP : (sel < 18) ? OPC_OP_IMM : 7'($urandom);
            rf3  = 3'($urandom);
            case ($urandom_range(0, 4))
               0: rf7 = 7'b0000000;
               1: rf7 = 7'b0100000;
               2: rf7 = 7'b0000001;
               3: rf7 = 7'b0100001;
               default: rf7 = 7'($urandom);
            endcase
            rrs1 = {$urandom, $urandom};
            rrs2 = {$urandom, $urandom};
            rimm = {{52{rf7[6]}}, rf7, 5'($urandom)};
            rrd  = 5'($urandom);
            rv   = ($urandom_range(0, 3) != 0);
         end
         rordy = ($urandom_range(0, 2) != 0);
         rfl   = ($urandom_range(0, 39) == 0);
         applyStimulus(rv, ropc, rf3, rf7, rrs1, rrs2, rimm, rrd, rordy, rfl, acc);
         pending = rv && !acc && !rfl;
      end

      repeat (4) idleCycle(1'b1);
      checkOutput("final drained", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
